apb_slave: RTL
==============

# apb_slave

APB completer (slave) that terminates the transfers issued by the team's `apb` requester. It decodes a small word-addressed register file and inserts a configurable number of wait states. It flags `pslverr` on out-of-range or misaligned accesses. It sits on the `apb_intf` bus opposite the requester and is the standalone responder model in the block-level environment.

## Interface

**Parameters**

- `ADDR_W`, default 8: width of `paddr`.
- `DATA_W`, default 32: width of `pwdata` and `prdata`.
- `DEPTH`, default 16: number of 32-bit registers.

**Ports** (clock and reset first)

- `pclk`, input, 1: bus clock. The block has one clock, and all state changes on the rising edge.
- `preset_n`, input, 1: asynchronous active-low reset.
- `pselx`, input, 1: slave select.
- `penable`, input, 1: access phase indicator.
- `pwrite`, input, 1: 1 = write, 0 = read.
- `paddr`, input, ADDR_W: byte address.
- `pwdata`, input, DATA_W: write data.
- `wait_cfg_i`, input, 4: number of wait states, sampled in the SETUP phase.
- `prdata`, output, DATA_W: read data.
- `pready`, output, 1: transfer completes this cycle.
- `pslverr`, output, 1: transfer error, valid only while `pready`=1.

## Operation

**States:** IDLE, SETUP, ACCESS.

- **IDLE**
  - `pselx`=1 and `penable`=0 → SETUP.
  - `penable`=1 without a preceding SETUP is ignored; the block stays in IDLE.
- **SETUP** (one cycle, entered on the edge after select)
  - Latch `paddr`, `pwrite`, `pwdata` and `wait_cfg_i` into the wait counter `wcnt`.
  - Always → ACCESS.
- **ACCESS**
  - `pready` = (`wcnt`==0).
  - While `wcnt`>0, decrement once per cycle.
  - On completion (`pready`=1 at the edge):
    - `pselx`=1 and `penable`=0 → SETUP (back-to-back transfer).
    - otherwise → IDLE.
  - `pselx`=0 mid-ACCESS (requester abort) → IDLE with no side effect.

**Decode**

- Index = latched `paddr[ADDR_W-1:2]`.
- Error = (index ≥ DEPTH) or (`paddr[1:0]` ≠ 0).

**Write**

- Commit to `mem[index]` at the completion edge when not in error.
- An errored write leaves memory unchanged.

**Read**

- `prdata` = `mem[index]` while `pready`=1 and not in error.
- Otherwise `prdata` = 0, including all errored reads.

**Reset**

- State goes to IDLE, `wcnt` to 0, and all `mem` entries to 0.
- `prdata`=0, `pready`=0, `pslverr`=0.
- A reset during ACCESS aborts the transfer with no write.

## Timing

- Latency from SETUP to completion is 1 + `wait_cfg_i` cycles.
- With `wait_cfg_i`=0, `pready` is high in the first ACCESS cycle.
- `pready`, `pslverr` and `prdata` are combinational decodes of the registered state and `wcnt`. They are glitch-free relative to `pclk`.
- `pslverr` is asserted only in the completion cycle.
- A write is visible to a read issued in the next SETUP.
- Mid-transfer changes on `wait_cfg_i`, `paddr` and `pwdata` are ignored because these values are latched in SETUP.

## Structure

- **Package `apb_common`** gains:
  - `apb_slv_state_e` enum with IDLE, SETUP, ACCESS.
  - Default width constants for `ADDR_W`, `DATA_W` and `DEPTH`.
  - The `WAIT_W`=4 constant.
- **Sub-module `apb_slave_mem`:**
  - Synchronous-write, combinational-read register array with asynchronous clear.
  - Ports: `pclk`, `preset_n`, `we`, `widx`, `wdata`, `ridx`, `rdata`.
- The FSM, wait counter and decode live in `apb_slave`.

## Test plan

1. **Zero-wait write then read.** Drive `wait_cfg_i`=0, write 0xDEADBEEF to 0x08, then read 0x08. Expect `pready` in the first ACCESS cycle of each transfer, `prdata`=0xDEADBEEF and `pslverr`=0.
2. **Wait states.** Drive `wait_cfg_i`=3 and read 0x04 after reset. Expect `pready` low for 3 ACCESS cycles and high on the 4th, with `prdata`=0.
3. **Out-of-range address.** Write 0x12345678 to 0x40 (index 16, DEPTH 16). Expect `pslverr`=1 with `pready`. A subsequent read of 0x00 returns 0, confirming there was no aliasing.
4. **Misaligned address.** Read 0x05. Expect `pslverr`=1 and `prdata`=0.
5. **Back-to-back transfers.** Write 0x0C=0xA5A5A5A5, go straight to SETUP with no IDLE cycle, then read 0x0C. Expect the second transfer to complete with 0xA5A5A5A5.
6. **Reset mid-ACCESS.** With `wait_cfg_i`=5, start a write of 0x11 to 0x00 and assert `preset_n`=0 in the 2nd ACCESS cycle. Expect all outputs at 0 immediately, and a read of 0x00 after reset returns 0.

Source files
------------

// File: rtl/apb_common.sv
// ----------------------------------------------------------------------------
// apb_common
//   Shared APB definitions: completer FSM state type, default bus/register
//   file dimensions and the wait-state counter width.
// ----------------------------------------------------------------------------
package apb_common;

    // Completer-side FSM states
    typedef enum logic [1:0] {
        SLV_IDLE   = 2'd0,
        SLV_SETUP  = 2'd1,
        SLV_ACCESS = 2'd2
    } apb_slv_state_e;

    // Default dimensions
    localparam int unsigned APB_ADDR_W = 8;
    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned APB_DEPTH  = 16;

    // Width of the wait-state configuration / counter
    localparam int unsigned WAIT_W = 4;

endpackage : apb_common

// File: rtl/apb_slave_mem.sv
// ----------------------------------------------------------------------------
// apb_slave_mem
//   Register array behind the APB completer: synchronous write, combinational
//   read, asynchronous clear of every entry.
//
//   pclk      in   clock (rising edge)
//   preset_n  in   asynchronous active-low reset, clears all entries
//   we        in   write enable
//   widx      in   write index
//   wdata     in   write data
//   ridx      in   read index
//   rdata     out  read data (combinational)
// ----------------------------------------------------------------------------
module apb_slave_mem
    import apb_common::*;
#(
    parameter int unsigned DATA_W = APB_DATA_W,
    parameter int unsigned DEPTH  = APB_DEPTH,
    parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[widx] <= wdata;
        end
    end

    assign rdata = mem_q[ridx];

endmodule : apb_slave_mem

// File: rtl/apb_slave.sv
// ----------------------------------------------------------------------------
// apb_slave
//   APB completer terminating transfers onto a small word-addressed register
//   file. The address, direction, write data and wait-state count are latched
//   when the request is accepted; the transfer then completes after
//   1 + wait_cfg_i cycles. Out-of-range or misaligned accesses complete with
//   pslverr and never touch memory.
//
//   pclk        in   bus clock (rising edge)
//   preset_n    in   asynchronous active-low reset
//   pselx       in   slave select
//   penable     in   access phase indicator
//   pwrite      in   1 = write, 0 = read
//   paddr       in   byte address
//   pwdata      in   write data
//   wait_cfg_i  in   number of wait states for the next transfer
//   prdata      out  read data, zero unless completing a good access
//   pready      out  transfer completes this cycle
//   pslverr     out  transfer error, only with pready
// ----------------------------------------------------------------------------
module apb_slave
    import apb_common::*;
#(
    parameter int unsigned ADDR_W = APB_ADDR_W,
    parameter int unsigned DATA_W = APB_DATA_W,
    parameter int unsigned DEPTH  = APB_DEPTH
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              pselx,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [WAIT_W-1:0] wait_cfg_i,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    apb_slv_state_e    state_q, state_d;
    logic [WAIT_W-1:0] wcnt_q,  wcnt_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              start;
    logic              done;
    logic              err;
    logic              mem_we;
    logic [ADDR_W-3:0] idx;
    logic [DATA_W-1:0] mem_rdata;

    assign start = pselx && !penable;
    assign done  = (state_q == SLV_ACCESS) && (wcnt_q == '0);

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;

        case (state_q)
            SLV_IDLE: begin
                if (start) state_d = SLV_SETUP;
            end
            SLV_SETUP: begin
                state_d = SLV_ACCESS;
            end
            SLV_ACCESS: begin
                if (!pselx) begin
                    state_d = SLV_IDLE;          // requester abort
                end else if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - WAIT_W'(1);
                end else if (start) begin
                    state_d = SLV_SETUP;         // back-to-back transfer
                end else begin
                    state_d = SLV_IDLE;
                end
            end
            default: begin
                state_d = SLV_IDLE;
            end
        endcase

        // Request fields are captured on every entry into SETUP, so later
        // bus changes during the transfer have no effect.
        if (state_d == SLV_SETUP) begin
            addr_d  = paddr;
            write_d = pwrite;
            wdata_d = pwdata;
            wcnt_d  = wait_cfg_i;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= SLV_IDLE;
            wcnt_q  <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
        end
    end

    // Decode uses the full word index so addresses beyond DEPTH never alias.
    assign idx    = addr_q[ADDR_W-1:2];
    assign err    = (32'(idx) >= DEPTH) || (addr_q[1:0] != 2'b00);
    assign mem_we = done && pselx && write_q && !err;

    apb_slave_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .pclk     (pclk),
        .preset_n (preset_n),
        .we       (mem_we),
        .widx     (idx[IDX_W-1:0]),
        .wdata    (wdata_q),
        .ridx     (idx[IDX_W-1:0]),
        .rdata    (mem_rdata)
    );

    assign pready  = done;
    assign pslverr = done && err;
    assign prdata  = (done && !err) ? mem_rdata : '0;

endmodule : apb_slave
